// File: rtl/grid_mem_arbiter.sv
// Arbitrates one shared bank port: the loader port always wins, compute requesters rotate round-robin.
// Only one access is in flight; a missing mem_ack is cut off by a watchdog that raises a sticky err.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif

// state    | meaning
// ST_IDLE  | no access; arbitrate loader first, then round-robin requesters
// ST_WAIT  | mem_en held with latched fields until mem_ack or watchdog expiry
// ST_ACK   | one-cycle completion pulse to the grantee
module grid_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROW_W   = `BANK_ADDR_WIDTH,
    parameter int COL_W   = `COL_ADDR_WIDTH,
    parameter int DATA_W  = `TX_DATA_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      pad_en_i,
    input  logic                      pad_write_en_i,
    input  logic                      pad_read_en_i,
    input  logic [ROW_W-1:0]          pad_row_i,
    input  logic [COL_W-1:0]          pad_col_i,
    input  logic [DATA_W-1:0]         pad_wdata_i,
    output logic                      pad_ack_o,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ROW_W-1:0]  req_row_i,
    input  logic [NUM_REQ*COL_W-1:0]  req_col_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ROW_W-1:0]          mem_row_o,
    output logic [COL_W-1:0]          mem_col_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_ack_i,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                is_pad_q, is_pad_d;
    logic                we_q, we_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;

    logic [ROW_W-1:0]    req_row_a   [NUM_REQ];
    logic [COL_W-1:0]    req_col_a   [NUM_REQ];
    logic [DATA_W-1:0]   req_wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_row_a[g]   = req_row_i[g*ROW_W +: ROW_W];
        assign req_col_a[g]   = req_col_i[g*COL_W +: COL_W];
        assign req_wdata_a[g] = req_wdata_i[g*DATA_W +: DATA_W];
    end

    logic            pad_req;
    logic            rr_hit;
    logic [ID_W-1:0] rr_id;
    logic [ID_W-1:0] cand_id;

    assign pad_req = pad_en_i && (pad_write_en_i || pad_read_en_i);

    // Search starts just after the last compute grantee so every requester gets a turn.
    always_comb begin
        rr_hit  = 1'b0;
        rr_id   = '0;
        cand_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_id = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!rr_hit && req_valid_i[cand_id]) begin
                rr_hit = 1'b1;
                rr_id  = cand_id;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        last_d   = last_q;
        is_pad_d = is_pad_q;
        we_d     = we_q;
        row_d    = row_q;
        col_d    = col_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wd_d     = wd_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pad_req) begin
                    state_d  = ST_WAIT;
                    is_pad_d = 1'b1;
                    we_d     = pad_write_en_i;
                    row_d    = pad_row_i;
                    col_d    = pad_col_i;
                    wdata_d  = pad_wdata_i;
                    wd_d     = '0;
                end else if (rr_hit) begin
                    state_d  = ST_WAIT;
                    is_pad_d = 1'b0;
                    id_d     = rr_id;
                    we_d     = req_we_i[rr_id];
                    row_d    = req_row_a[rr_id];
                    col_d    = req_col_a[rr_id];
                    wdata_d  = req_wdata_a[rr_id];
                    wd_d     = '0;
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = ST_ACK;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_ACK;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (!is_pad_q) last_d = id_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
            is_pad_q <= 1'b0;
            we_q     <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            last_q   <= last_d;
            is_pad_q <= is_pad_d;
            we_q     <= we_d;
            row_q    <= row_d;
            col_q    <= col_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    assign mem_en_o    = (state_q == ST_WAIT);
    assign mem_we_o    = we_q;
    assign mem_row_o   = row_q;
    assign mem_col_o   = col_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign pad_ack_o   = (state_q == ST_ACK) && is_pad_q;
    assign req_ack_o   = ((state_q == ST_ACK) && !is_pad_q) ? (NUM_REQ'(1) << id_q) : '0;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Scoreboard bench for grid_mem_arbiter: expected transactions are queued as stimulus is
// driven and matched against each ack; a bank model answers mem_en after a set delay.
module tb_grid_mem_arbiter;
    localparam int N   = 4;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pad_en, pad_write_en, pad_read_en;
    logic [7:0]     pad_row, pad_col, pad_wdata;
    logic           pad_ack;
    logic [N-1:0]   req_valid, req_we;
    logic [N*8-1:0] req_row, req_col, req_wdata;
    logic [N-1:0]   req_ack;
    logic [7:0]     rdata;
    logic           mem_en, mem_we;
    logic [7:0]     mem_row, mem_col, mem_wdata, mem_rdata;
    logic           mem_ack;
    logic           busy, err;

    grid_mem_arbiter #(.NUM_REQ(N), .ROW_W(8), .COL_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pad_en_i(pad_en), .pad_write_en_i(pad_write_en), .pad_read_en_i(pad_read_en),
        .pad_row_i(pad_row), .pad_col_i(pad_col), .pad_wdata_i(pad_wdata), .pad_ack_o(pad_ack),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_row_i(req_row), .req_col_i(req_col),
        .req_wdata_i(req_wdata), .req_ack_o(req_ack), .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_row_o(mem_row), .mem_col_o(mem_col),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         pad;
        int         id;
        bit         we;
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         tmo;
        bit         err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   cyc_en   = 0;
    int   ack_dly  = 2;
    bit   no_ack   = 1'b0;
    bit   spurious = 1'b0;
    bit   model_err = 1'b0;
    bit   en_prev  = 1'b0;
    int   resp_cnt = 0;
    int   req_cnt [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bank model: read data is row^col, so expected rdata follows from the request fields alone.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                resp_cnt++;
                mem_ack   = !no_ack && (resp_cnt == ack_dly + 1);
                mem_rdata = mem_row ^ mem_col;
            end else begin
                resp_cnt  = 0;
                mem_ack   = spurious;
                mem_rdata = 8'hEE;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_en && !en_prev) begin
                cyc_en = cyc;
                if (sb.size() == 0) chk("mem_en_unexpected", 1, 0);
                else begin
                    chk("mem_we", mem_we, sb[0].we);
                    chk("mem_row", mem_row, sb[0].row);
                    chk("mem_col", mem_col, sb[0].col);
                    if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            en_prev = mem_en;
            if (pad_ack || req_ack != '0) begin
                if (sb.size() == 0) chk("ack_unexpected", {pad_ack, req_ack}, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("pad_ack", pad_ack, mon_e.pad);
                    chk("req_ack", req_ack, mon_e.pad ? 32'd0 : (32'd1 << mon_e.id));
                    chk("rdata", rdata, mon_e.rdata);
                    chk("err", err, mon_e.err);
                    chk("ack_cycle", cyc, cyc_en + (mon_e.tmo ? TMO : ack_dly + 1));
                    if (mon_e.pad) pad_en = 1'b0;
                    else begin
                        req_cnt[mon_e.id]--;
                        if (req_cnt[mon_e.id] <= 0) req_valid[mon_e.id] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit pad, input int id, input bit we, input logic [7:0] row,
                            input logic [7:0] col, input logic [7:0] wd, input bit tmo);
        exp_t e;
        e.pad = pad; e.id = id; e.we = we; e.row = row; e.col = col; e.wdata = wd;
        e.tmo = tmo;
        e.rdata = tmo ? 8'h00 : (row ^ col);
        e.err = model_err || tmo;
        model_err = e.err;
        sb.push_back(e);
    endtask

    task automatic pad_drive(input bit wr, input bit rd, input logic [7:0] row,
                             input logic [7:0] col, input logic [7:0] wd);
        pad_write_en = wr; pad_read_en = rd;
        pad_row = row; pad_col = col; pad_wdata = wd;
        pad_en = 1'b1;
    endtask

    task automatic req_drive(input int i, input bit we, input logic [7:0] row,
                             input logic [7:0] col, input logic [7:0] wd, input int cnt);
        req_we[i] = we;
        req_row[i*8 +: 8] = row;
        req_col[i*8 +: 8] = col;
        req_wdata[i*8 +: 8] = wd;
        req_cnt[i] = cnt;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain", (sb.size() == 0) && !busy, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        pad_en = 1'b0; pad_write_en = 1'b0; pad_read_en = 1'b0;
        pad_row = '0; pad_col = '0; pad_wdata = '0;
        req_valid = '0; req_we = '0; req_row = '0; req_col = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) req_cnt[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_acks", {pad_ack, req_ack}, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // loader write, mem_ack two cycles after mem_en
        ack_dly = 2;
        push_exp(1, 0, 1, 8'd3, 8'd0, 8'hA5, 0);
        pad_drive(1, 0, 8'd3, 8'd0, 8'hA5);
        wait_done(100);
        chk("busy_after_pad", busy, 0);

        // both directions set: write wins; then a plain loader read
        push_exp(1, 0, 1, 8'h01, 8'h02, 8'h11, 0);
        pad_drive(1, 1, 8'h01, 8'h02, 8'h11);
        wait_done(100);
        ack_dly = 1;
        push_exp(1, 0, 0, 8'h05, 8'h07, 8'h00, 0);
        pad_drive(0, 1, 8'h05, 8'h07, 8'h00);
        wait_done(100);

        // mem_ack while idle must not start anything
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ack_busy", busy, 0);
        spurious = 1'b0;
        @(negedge clk);

        // all four requesting, requester 0 comes back once: order 0,1,2,3,0
        ack_dly = 0;
        push_exp(0, 0, 0, 8'h10, 8'h01, 8'h00, 0);
        push_exp(0, 1, 1, 8'h20, 8'h02, 8'h5A, 0);
        push_exp(0, 2, 0, 8'h40, 8'h04, 8'h00, 0);
        push_exp(0, 3, 1, 8'h80, 8'h08, 8'hC3, 0);
        push_exp(0, 0, 0, 8'h10, 8'h01, 8'h00, 0);
        req_drive(0, 0, 8'h10, 8'h01, 8'h00, 2);
        req_drive(1, 1, 8'h20, 8'h02, 8'h5A, 1);
        req_drive(2, 0, 8'h40, 8'h04, 8'h00, 1);
        req_drive(3, 1, 8'h80, 8'h08, 8'hC3, 1);
        wait_done(200);

        // loader and requester 2 in the same idle cycle: loader first
        ack_dly = 1;
        push_exp(1, 0, 1, 8'h0A, 8'h0B, 8'h77, 0);
        push_exp(0, 2, 0, 8'h22, 8'h33, 8'h00, 0);
        pad_drive(1, 0, 8'h0A, 8'h0B, 8'h77);
        req_drive(2, 0, 8'h22, 8'h33, 8'h00, 1);
        wait_done(100);

        // requester 1 read returning 8'h3C
        ack_dly = 3;
        push_exp(0, 1, 0, 8'h30, 8'h0C, 8'h00, 0);
        req_drive(1, 0, 8'h30, 8'h0C, 8'h00, 1);
        wait_done(100);

        // mem_ack never returns: watchdog ack, sticky err
        no_ack = 1'b1;
        push_exp(0, 3, 1, 8'h44, 8'h55, 8'h99, 1);
        req_drive(3, 1, 8'h44, 8'h55, 8'h99, 1);
        wait_done(200);
        no_ack = 1'b0;
        ack_dly = 1;
        push_exp(0, 0, 0, 8'h06, 8'h09, 8'h00, 0);
        req_drive(0, 0, 8'h06, 8'h09, 8'h00, 1);
        wait_done(100);
        chk("err_sticky", err, 1);

        // reset pulse mid-WAIT drops the access
        no_ack = 1'b1;
        push_exp(0, 1, 0, 8'h12, 8'h34, 8'h00, 0);
        req_drive(1, 0, 8'h12, 8'h34, 8'h00, 1);
        c = 0;
        while (!mem_en && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("rst_wait_en", mem_en, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_err", err, 0);
        chk("midrst_acks", {pad_ack, req_ack}, 0);
        sb.delete();
        model_err = 1'b0;
        req_valid = '0;
        no_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // after reset the rotation restarts at requester 0
        ack_dly = 2;
        push_exp(0, 0, 1, 8'h61, 8'h16, 8'hB4, 0);
        push_exp(0, 2, 0, 8'h62, 8'h26, 8'h00, 0);
        req_drive(2, 0, 8'h62, 8'h26, 8'h00, 1);
        req_drive(0, 1, 8'h61, 8'h16, 8'hB4, 1);
        wait_done(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
